// File: rtl/pulse_delay_stretch.sv
// ---------------------------------------------------------------------------
// pulse_delay_stretch
//
// Multi-channel programmable delay and pulse conditioner for the DAQ_SPI
// strobe and trigger paths. Each channel registers its input, passes it
// through a shift-register delay line, picks a tap selected by the delay
// setting, and then shapes the tapped signal in one of four modes:
//   00 DELAY   : output follows the tapped signal
//   01 STRETCH : retriggerable, adds L cycles after the tapped signal falls
//   10 ONESHOT : non-retriggerable, fixed L+1 cycle pulse per rising edge
//   11 FILTER  : passes only pulses longer than L cycles
// All channels share one configuration register set. The latency from in to
// out is (delay + 2) cycles in every mode.
//
// Ports:
//   clk       system clock, single domain
//   rst_n     asynchronous active-low reset
//   in        raw per-channel inputs, synchronous to clk
//   cfg_load  one-cycle strobe: latch cfg_* and flush the whole datapath
//   cfg_dly   delay in cycles, 0..DLY_DEPTH (larger values clamp)
//   cfg_len   stretch / filter length L
//   cfg_mode  shaping mode (see above)
//   out       conditioned outputs, registered
//   busy      per-channel counter non-zero, registered
// ---------------------------------------------------------------------------
module pulse_delay_stretch #(
    parameter int CH        = 4,
    parameter int DLY_DEPTH = 16,
    parameter int LEN_W     = 5,
    parameter int RST_DLY   = 0,
    parameter int RST_LEN   = 4,
    parameter int RST_MODE  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CH-1:0]                  in,
    input  logic                           cfg_load,
    input  logic [$clog2(DLY_DEPTH+1)-1:0] cfg_dly,
    input  logic [LEN_W-1:0]               cfg_len,
    input  logic [1:0]                     cfg_mode,
    output logic [CH-1:0]                  out,
    output logic [CH-1:0]                  busy
);

    localparam int DW = $clog2(DLY_DEPTH + 1);
    localparam logic [DW-1:0] DLY_MAX = DW'(DLY_DEPTH);

    typedef enum logic [1:0] {
        MODE_DELAY   = 2'b00,
        MODE_STRETCH = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_FILTER  = 2'b11
    } mode_e;

    // -----------------------------------------------------------------------
    // Shared configuration registers
    // -----------------------------------------------------------------------
    logic [DW-1:0]    dly_q, dly_d;
    logic [LEN_W-1:0] len_q, len_d;
    mode_e            mode_q, mode_d;

    always_comb begin
        dly_d  = dly_q;
        len_d  = len_q;
        mode_d = mode_q;
        if (cfg_load) begin
            // Out-of-range delays clamp to the last tap of the line.
            dly_d  = (cfg_dly > DLY_MAX) ? DLY_MAX : cfg_dly;
            len_d  = cfg_len;
            mode_d = mode_e'(cfg_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q  <= DW'(RST_DLY);
            len_q  <= LEN_W'(RST_LEN);
            mode_q <= mode_e'(2'(RST_MODE));
        end else begin
            dly_q  <= dly_d;
            len_q  <= len_d;
            mode_q <= mode_d;
        end
    end

    // -----------------------------------------------------------------------
    // Input register (all channels). The sample taken in a load cycle is
    // dropped so the new configuration starts from a clean pipeline.
    // -----------------------------------------------------------------------
    logic [CH-1:0] in_q, in_d;

    always_comb begin
        in_d = cfg_load ? '0 : in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= in_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel delay line and shaper
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [DLY_DEPTH-1:0] sr_q, sr_d;
        logic [DLY_DEPTH:0]   taps;
        logic                 d;
        logic [LEN_W-1:0]     cnt_q, cnt_d;
        logic                 d_prev_q, d_prev_d;
        logic                 out_q, out_d;
        logic                 busy_q, busy_d;

        always_comb begin
            // taps[0] is in_q itself, taps[k] is in_q delayed by k cycles, so
            // the delay setting indexes the tap vector directly.
            taps     = {sr_q, in_q[gi]};
            d        = taps[dly_q];
            sr_d     = {sr_q[DLY_DEPTH-2:0], in_q[gi]};
            d_prev_d = d;
            busy_d   = (cnt_q != '0);
            cnt_d    = cnt_q;
            out_d    = 1'b0;

            case (mode_q)
                MODE_DELAY: begin
                    cnt_d = '0;
                    out_d = d;
                end
                MODE_STRETCH: begin
                    // Reload on every high cycle, so a new pulse during the
                    // tail restarts the L-cycle extension.
                    if (d) begin
                        cnt_d = len_q;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                    out_d = d | (cnt_q != '0);
                end
                MODE_ONESHOT: begin
                    // Rising edges are only honoured while idle; the cycle of
                    // the rise plus L counted cycles gives an L+1 pulse.
                    if ((cnt_q == '0) && d && !d_prev_q) begin
                        cnt_d = len_q;
                        out_d = 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        out_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                        out_d = 1'b0;
                    end
                end
                MODE_FILTER: begin
                    // Count consecutive high cycles, saturating at L; the
                    // output opens only once L high cycles have been seen.
                    if (d) begin
                        cnt_d = (cnt_q == len_q) ? len_q : cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                    out_d = d && (cnt_q == len_q);
                end
                default: begin
                    cnt_d = '0;
                    out_d = 1'b0;
                end
            endcase

            if (cfg_load) begin
                sr_d     = '0;
                cnt_d    = '0;
                d_prev_d = 1'b0;
                out_d    = 1'b0;
                busy_d   = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q     <= '0;
                cnt_q    <= '0;
                d_prev_q <= 1'b0;
                out_q    <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                sr_q     <= sr_d;
                cnt_q    <= cnt_d;
                d_prev_q <= d_prev_d;
                out_q    <= out_d;
                busy_q   <= busy_d;
            end
        end

        assign out[gi]  = out_q;
        assign busy[gi] = busy_q;
    end

endmodule

// File: doc/pulse_delay_stretch.md
Name: pulse_delay_stretch

Overview:
Multi-channel programmable delay and pulse conditioner for the DAQ_SPI strobe and trigger paths. Each channel is delayed by a runtime-selected number of cycles and then shaped by one of four modes: delay-only, retriggerable stretch, non-retriggerable one-shot, or minimum-width filter. With the reset configuration (no delay, retriggerable stretch of 4 cycles) each channel keeps its input-high cycles and adds 4 cycles after the input falls. All channels share one configuration register set.

Parameters:
CH, 4, number of independent channels
DLY_DEPTH, 16, maximum programmable delay in cycles; delay-line length per channel
LEN_W, 5, width of the stretch/filter length field
RST_DLY, 0, cfg_dly value loaded at reset
RST_LEN, 4, cfg_len value loaded at reset
RST_MODE, 1, cfg_mode value loaded at reset (retriggerable stretch)

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
in  input  CH  raw per-channel inputs, synchronous to clk
cfg_load  input  1  one-cycle strobe: latch cfg_dly/cfg_len/cfg_mode and flush the datapath
cfg_dly  input  $clog2(DLY_DEPTH+1)  delay in cycles, 0..DLY_DEPTH
cfg_len  input  LEN_W  stretch/filter length L
cfg_mode  input  2  00 DELAY, 01 STRETCH, 10 ONESHOT, 11 FILTER
out  output  CH  conditioned outputs, registered
busy  output  CH  per-channel counter non-zero, registered

Behaviour:
- Reset (rst_n low, asynchronous): out=0, busy=0, in_q=0, delay lines=0, counters=0, d_prev=0. Config registers take RST_DLY/RST_LEN/RST_MODE.
- Reset release: outputs start updating on the first clk edge after rst_n goes high.
- Per-channel pipeline: in_q <= in; sr <= {sr[DLY_DEPTH-2:0], in_q}.
- Delay tap: d = in_q when dly_q=0, otherwise sr[dly_q-1].
- cfg_dly > DLY_DEPTH is clamped to DLY_DEPTH when latched.
- Latency from in to out: dly_q + 2 cycles in every mode.
- DELAY (00): out <= d. Counter held at 0.
- STRETCH (01):
  - cnt <= d ? L : (cnt!=0 ? cnt-1 : 0).
  - out <= d | (cnt!=0).
  - Output is high for all d-high cycles plus L cycles after d falls.
  - A new d pulse during the tail reloads L (retriggerable).
  - L=0 behaves as DELAY.
- ONESHOT (10):
  - Rise is d & ~d_prev.
  - If cnt=0 and rise: cnt <= L, out <= 1.
  - Else if cnt!=0: cnt <= cnt-1, out <= 1.
  - Else: out <= 0.
  - Output pulse is exactly L+1 cycles regardless of d width. Rises during an active pulse are ignored.
  - d held high produces no further pulses until it falls and rises again.
- FILTER (11):
  - If d=1: cnt <= (cnt==L) ? L : cnt+1. If d=0: cnt <= 0.
  - out <= d & (cnt==L).
  - The first high output occurs L+1 cycles after d rises; out drops together with d.
  - d pulses of L cycles or fewer are suppressed. L=0 behaves as DELAY.
- busy = registered (cnt!=0) per channel.
- Counters are LEN_W wide and never wrap: they saturate at L and floor at 0.
- cfg_load (synchronous, highest priority after reset):
  - New config latched on that edge.
  - in_q, sr, cnt, d_prev, out and busy all cleared on that edge.
  - The input sampled in the load cycle is discarded.
  - New config governs behaviour from the next cycle.
  - A cfg_load held high keeps the datapath flushed.
- Config changes without cfg_load have no effect.
- Channels are fully independent: simultaneous events on different channels do not interact.

Test Plan:
- Reset defaults (STRETCH, L=4, dly=0), in[0] high for 1 cycle at T -> out[0] high at T+2..T+6 (5 cycles), busy[0] high at T+3..T+6.
- Load dly=5, mode=00, in[1] high for 3 cycles at T -> out[1] high at T+7..T+9; dly=20 on a DLY_DEPTH=16 build reads back 16-cycle delay (out at T+18).
- ONESHOT, L=3, dly=0, in[2] held high for 10 cycles, then a second rise 2 cycles after the first pulse ends -> first out pulse exactly 4 cycles starting T+2; the second rise gives a second 4-cycle pulse. A rise 1 cycle into an active pulse gives no extension.
- FILTER, L=3: in[3] high 3 cycles -> out[3] stays 0. in[3] high 8 cycles at T -> out[3] high at T+5..T+9.
- STRETCH L=4, second 1-cycle pulse 2 cycles after the first -> single merged high run of 8 cycles. All 4 channels driven with staggered pulses match per-channel model independently.
- Asynchronous rst_n asserted mid-stretch (cnt=2) -> out and busy low immediately, without a clk edge. cfg_load mid-delay (dly=8, pulse in line) -> pulse never appears; out=0 from the next edge.
